// File: rtl/usb_rx_pkg.sv
// Shared types and line constants for the USB receive line decoder.
package usb_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP1,
    ST_EOP2,
    ST_DRAIN
  } rx_state_e;

  localparam logic [1:0] SE0  = 2'b00;
  localparam logic [1:0] SE1  = 2'b11;
  localparam logic [1:0] J_FS = 2'b10;

  localparam int STUFF_LIMIT_DEF    = 6;
  localparam int SYNC_MIN_ZEROS_DEF = 5;

endpackage

// File: rtl/usb_rx_line_decoder_if.sv
// Byte stream with packet framing from the line decoder to the packet parser.
// valid/ready: there is no ready; rx_valid, rx_sop, rx_eop and rx_error are
// single-cycle strobes the consumer must take on the cycle they are high.
interface usb_rx_line_decoder_if;
  import usb_rx_pkg::*;

  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_active;
  logic       rx_sop;
  logic       rx_eop;
  logic       rx_error;
  rx_state_e  fsm_state;

  modport master (
    output rx_data, rx_valid, rx_active, rx_sop, rx_eop, rx_error, fsm_state
  );

  modport slave (
    input rx_data, rx_valid, rx_active, rx_sop, rx_eop, rx_error, fsm_state
  );

endinterface

// File: rtl/usb_rx_bit_sampler.sv
// Synchronizes the raw line and strobes once per bit near the bit centre,
// re-aligning the phase on every line transition.
module usb_rx_bit_sampler
  import usb_rx_pkg::*;
#(
  parameter int OVERSAMPLE = 4
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] line,
  output logic       sample_en,
  output logic [1:0] sample_sym
);

  localparam int              PW     = $clog2(OVERSAMPLE);
  localparam logic [PW-1:0]   CENTRE = PW'(OVERSAMPLE / 2 - 1);

  logic [1:0]    sync1;
  logic [1:0]    line_s;
  logic [1:0]    line_d;
  logic [PW-1:0] phase;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1  <= J_FS;
      line_s <= J_FS;
      line_d <= J_FS;
      phase  <= '0;
    end else begin
      sync1  <= line;
      line_s <= sync1;
      line_d <= line_s;
      // Free-running phase wraps naturally because OVERSAMPLE is a power of two.
      if (line_s != line_d) phase <= '0;
      else                  phase <= phase + 1'b1;
    end
  end

  assign sample_en  = (phase == CENTRE);
  assign sample_sym = line_s;

endmodule

// File: rtl/usb_rx_line_decoder.sv
// NRZI decode, SYNC detect, bit unstuffing and EOP detection on the sampled
// line, producing framed bytes for the packet parser.
module usb_rx_line_decoder
  import usb_rx_pkg::*;
#(
  parameter int OVERSAMPLE     = 4,
  parameter int SYNC_MIN_ZEROS = SYNC_MIN_ZEROS_DEF,
  parameter int STUFF_LIMIT    = STUFF_LIMIT_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [1:0]            usb_signals,
  input  logic [1:0]            j_state,
  input  logic [1:0]            k_state,
  input  logic                  bus_reset,
  usb_rx_line_decoder_if.master rx
);

  localparam logic [2:0] STUFF_L = 3'(STUFF_LIMIT);
  localparam logic [2:0] SYNC_L  = 3'(SYNC_MIN_ZEROS);

  logic       sample_en;
  logic [1:0] sample_sym;

  usb_rx_bit_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
    .clock      (clock),
    .reset_n    (reset_n),
    .line       (usb_signals),
    .sample_en  (sample_en),
    .sample_sym (sample_sym)
  );

  rx_state_e  state_q, state_n;
  logic [1:0] prev_q, prev_n;
  logic [2:0] zero_q, zero_n, ones_q, ones_n, bit_q, bit_n;
  logic [1:0] se0_q, se0_n;
  logic       jseen_q, jseen_n;
  logic [7:0] shreg_q, shreg_n, data_q, data_n;
  logic       valid_q, valid_n, sop_q, sop_n, eop_q, eop_n, err_q, err_n;
  logic       active_q, active_n;

  logic is_se0, is_se1, is_jk, is_j, is_k, nrzi_bit;

  assign is_se0   = (sample_sym == SE0);
  assign is_se1   = (sample_sym == SE1);
  assign is_jk    = !is_se0 && !is_se1;
  assign is_j     = (sample_sym == j_state);
  assign is_k     = (sample_sym == k_state);
  assign nrzi_bit = (sample_sym == prev_q);

  always_comb begin
    state_n = state_q;
    prev_n  = prev_q;
    zero_n  = zero_q;
    ones_n  = ones_q;
    bit_n   = bit_q;
    se0_n   = se0_q;
    jseen_n = jseen_q;
    shreg_n = shreg_q;
    data_n  = data_q;
    valid_n = 1'b0;
    sop_n   = 1'b0;
    eop_n   = 1'b0;
    err_n   = 1'b0;

    if (sample_en && is_jk)       prev_n = sample_sym;
    else if (state_q == ST_IDLE)  prev_n = j_state;

    if (bus_reset) begin
      state_n = ST_IDLE;
      zero_n  = '0;
      ones_n  = '0;
      bit_n   = '0;
      se0_n   = '0;
      jseen_n = 1'b0;
    end else if (sample_en) begin
      case (state_q)
        ST_IDLE: begin
          if (is_k) begin
            state_n = ST_SYNC;
            zero_n  = 3'd1;
          end
        end
        ST_SYNC: begin
          if (!is_jk) begin
            state_n = ST_IDLE;
          end else if (!nrzi_bit) begin
            if (zero_q != 3'd7) zero_n = zero_q + 3'd1;
          end else if (zero_q >= SYNC_L) begin
            state_n = ST_DATA;
            sop_n   = 1'b1;
            ones_n  = 3'd1;  // the SYNC-terminating 1 counts toward stuffing
            bit_n   = '0;
          end else begin
            state_n = ST_IDLE;
          end
        end
        ST_DATA: begin
          if (is_se0) begin
            state_n = ST_EOP1;
            err_n   = (bit_q != 3'd0);
            bit_n   = '0;
          end else if (is_se1) begin
            state_n = ST_DRAIN;
            err_n   = 1'b1;
          end else if (ones_q == STUFF_L) begin
            if (nrzi_bit) begin
              state_n = ST_DRAIN;
              err_n   = 1'b1;
            end else begin
              ones_n = '0;
            end
          end else begin
            shreg_n = {nrzi_bit, shreg_q[7:1]};
            ones_n  = nrzi_bit ? ones_q + 3'd1 : 3'd0;
            if (bit_q == 3'd7) begin
              bit_n   = '0;
              data_n  = shreg_n;
              valid_n = 1'b1;
            end else begin
              bit_n = bit_q + 3'd1;
            end
          end
        end
        ST_EOP1: begin
          if (is_se0) begin
            state_n = ST_EOP2;
            se0_n   = '0;
          end else begin
            state_n = ST_DRAIN;
            err_n   = 1'b1;
          end
        end
        ST_EOP2: begin
          if (is_j) begin
            state_n = ST_IDLE;
            eop_n   = 1'b1;
          end else if (is_se0 && se0_q != 2'd2) begin
            se0_n = se0_q + 2'd1;
          end else begin
            state_n = ST_DRAIN;
            err_n   = 1'b1;
          end
        end
        ST_DRAIN: begin
          jseen_n = is_j && !jseen_q;
          if (is_j && jseen_q) state_n = ST_IDLE;
        end
        default: state_n = ST_IDLE;
      endcase
    end

    active_n = (state_n == ST_DATA) || (state_n == ST_EOP1) || (state_n == ST_EOP2);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      prev_q   <= J_FS;
      zero_q   <= '0;
      ones_q   <= '0;
      bit_q    <= '0;
      se0_q    <= '0;
      jseen_q  <= 1'b0;
      shreg_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      sop_q    <= 1'b0;
      eop_q    <= 1'b0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      prev_q   <= prev_n;
      zero_q   <= zero_n;
      ones_q   <= ones_n;
      bit_q    <= bit_n;
      se0_q    <= se0_n;
      jseen_q  <= jseen_n;
      shreg_q  <= shreg_n;
      data_q   <= data_n;
      valid_q  <= valid_n;
      sop_q    <= sop_n;
      eop_q    <= eop_n;
      err_q    <= err_n;
      active_q <= active_n;
    end
  end

  assign rx.rx_data   = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.rx_active = active_q;
  assign rx.rx_sop    = sop_q;
  assign rx.rx_eop    = eop_q;
  assign rx.rx_error  = err_q;
  assign rx.fsm_state = state_q;

endmodule

// File: tb/tb_usb_rx_line_decoder.sv
// Directed bench: NRZI-encoded full-speed packets are built as symbol lists
// and played onto the line; decoded bytes and framing strobes are checked.
module tb_usb_rx_line_decoder;
  import usb_rx_pkg::*;

  localparam logic [1:0] J = 2'b10;
  localparam logic [1:0] K = 2'b01;

  // Clock / reset
  logic       clock;
  logic       reset_n;
  logic [1:0] usb_signals;
  logic       bus_reset;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  usb_rx_line_decoder_if rx_if ();

  usb_rx_line_decoder dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .usb_signals (usb_signals),
    .j_state     (J),
    .k_state     (K),
    .bus_reset   (bus_reset),
    .rx          (rx_if.master)
  );

  // Monitor: records strobes and received bytes
  logic [7:0] got_data[$];
  logic [7:0] exp_q[$];
  int sop_cnt = 0, valid_cnt = 0, eop_cnt = 0, err_cnt = 0, overlap_cnt = 0;

  always @(negedge clock) begin
    if (rx_if.rx_valid) begin
      got_data.push_back(rx_if.rx_data);
      valid_cnt++;
    end
    if (rx_if.rx_sop)   sop_cnt++;
    if (rx_if.rx_eop)   eop_cnt++;
    if (rx_if.rx_error) err_cnt++;
    if (rx_if.rx_valid && rx_if.rx_error) overlap_cnt++;
  end

  // Scoreboard state
  int tests = 0;
  int fails = 0;
  int rd_idx = 0;
  int b_sop, b_val, b_eop, b_err;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_bytes(input string tag);
    logic [7:0] e;
    int extra;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd_idx < got_data.size()) check({tag, "_byte"}, 32'(got_data[rd_idx]), 32'(e));
      else                          check({tag, "_missing"}, 32'hFFFF_FFFF, 32'(e));
      rd_idx++;
    end
    extra = (got_data.size() > rd_idx) ? got_data.size() - rd_idx : 0;
    check({tag, "_extra"}, 32'(extra), 32'd0);
    rd_idx = got_data.size();
  endtask

  task automatic snap();
    b_sop = sop_cnt;
    b_val = valid_cnt;
    b_eop = eop_cnt;
    b_err = err_cnt;
  endtask

  task automatic check_counts(input string tag, input int s, input int v, input int e, input int r);
    check({tag, "_sop"},   32'(sop_cnt - b_sop),   32'(s));
    check({tag, "_valid"}, 32'(valid_cnt - b_val), 32'(v));
    check({tag, "_eop"},   32'(eop_cnt - b_eop),   32'(e));
    check({tag, "_err"},   32'(err_cnt - b_err),   32'(r));
  endtask

  // Driver: symbol list built bit by bit, then played as runs
  logic [1:0] sym_q[$];
  logic [1:0] cur;
  int         ones;

  task automatic drive(input logic [1:0] sym, input int n);
    @(negedge clock);
    usb_signals = sym;
    repeat (n - 1) @(negedge clock);
  endtask

  task automatic play(input bit jit);
    int i, n, len;
    bit up;
    up = 1'b1;
    i  = 0;
    while (i < sym_q.size()) begin
      n = 1;
      while (i + n < sym_q.size() && sym_q[i + n] == sym_q[i]) n++;
      len = 4 * n;
      if (jit) begin
        len = up ? len + 1 : len - 1;
        up  = !up;
      end
      drive(sym_q[i], len);
      i += n;
    end
    sym_q.delete();
  endtask

  task automatic push_bit(input logic b);
    if (!b) cur = (cur == J) ? K : J;
    sym_q.push_back(cur);
  endtask

  task automatic push_idle(input int nbits);
    cur = J;
    repeat (nbits) sym_q.push_back(J);
  endtask

  task automatic push_sync();
    repeat (7) push_bit(1'b0);
    push_bit(1'b1);
    ones = 1;
  endtask

  task automatic push_data_bit(input logic b);
    push_bit(b);
    ones = b ? ones + 1 : 0;
    if (ones == 6) begin
      push_bit(1'b0);
      ones = 0;
    end
  endtask

  task automatic push_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) push_data_bit(v[i]);
  endtask

  task automatic push_eop();
    sym_q.push_back(SE0);
    sym_q.push_back(SE0);
    cur = J;
    sym_q.push_back(J);
  endtask

  initial begin
    reset_n     = 1'b0;
    usb_signals = J;
    bus_reset   = 1'b0;
    cur         = J;
    ones        = 0;
    repeat (3) @(negedge clock);

    // Reset state
    check("rst_data",   32'(rx_if.rx_data),   32'h0);
    check("rst_valid",  32'(rx_if.rx_valid),  32'h0);
    check("rst_active", 32'(rx_if.rx_active), 32'h0);
    check("rst_state",  32'(rx_if.fsm_state), 32'(ST_IDLE));
    reset_n = 1'b1;
    push_idle(4);
    play(1'b0);

    // Basic packet 0xC3 0x5A
    snap();
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h5A);
    push_idle(2); push_sync(); push_byte(8'hC3); push_byte(8'h5A); push_eop(); push_idle(4);
    play(1'b0);
    repeat (8) @(negedge clock);
    check_bytes("basic");
    check_counts("basic", 1, 2, 1, 0);
    check("basic_idle", 32'(rx_if.fsm_state), 32'(ST_IDLE));

    // Bit stuffing 0xFF 0x01
    snap();
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h01);
    push_idle(2); push_sync(); push_byte(8'hFF); push_byte(8'h01); push_eop(); push_idle(4);
    play(1'b0);
    repeat (8) @(negedge clock);
    check_bytes("stuff");
    check_counts("stuff", 1, 2, 1, 0);

    // Stuff error: seven unstuffed 1s
    snap();
    push_idle(2); push_sync();
    repeat (7) push_bit(1'b1);
    play(1'b0);
    check("stferr_active", 32'(rx_if.rx_active), 32'h0);
    check("stferr_state",  32'(rx_if.fsm_state), 32'(ST_DRAIN));
    push_idle(6);
    play(1'b0);
    repeat (8) @(negedge clock);
    check_counts("stferr", 1, 0, 0, 1);
    check("stferr_idle", 32'(rx_if.fsm_state), 32'(ST_IDLE));

    // Partial byte then EOP
    snap();
    push_idle(2); push_sync();
    push_data_bit(1'b1); push_data_bit(1'b0); push_data_bit(1'b1);
    push_data_bit(1'b1); push_data_bit(1'b0);
    push_eop(); push_idle(4);
    play(1'b0);
    repeat (8) @(negedge clock);
    check_counts("partial", 1, 0, 1, 1);
    check_bytes("partial");

    // Jittered edges over 0x96
    snap();
    exp_q.push_back(8'h96);
    push_idle(3); push_sync(); push_byte(8'h96); push_eop(); push_idle(4);
    play(1'b1);
    repeat (8) @(negedge clock);
    check_bytes("jitter");
    check_counts("jitter", 1, 1, 1, 0);

    // bus_reset mid-byte
    snap();
    push_idle(2); push_sync();
    push_data_bit(1'b0); push_data_bit(1'b1); push_data_bit(1'b1); push_data_bit(1'b0);
    play(1'b0);
    check("busrst_pre_active", 32'(rx_if.rx_active), 32'h1);
    @(negedge clock);
    bus_reset = 1'b1;
    @(negedge clock);
    bus_reset = 1'b0;
    check("busrst_active", 32'(rx_if.rx_active), 32'h0);
    check("busrst_state",  32'(rx_if.fsm_state), 32'(ST_IDLE));
    push_idle(6);
    play(1'b0);
    repeat (8) @(negedge clock);
    check_counts("busrst", 1, 0, 0, 0);

    // Async reset mid-DATA, then a normal packet 0xA5
    push_idle(2); push_sync();
    push_data_bit(1'b1); push_data_bit(1'b0); push_data_bit(1'b1);
    play(1'b0);
    check("arst_pre_active", 32'(rx_if.rx_active), 32'h1);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    check("arst_active", 32'(rx_if.rx_active), 32'h0);
    check("arst_data",   32'(rx_if.rx_data),   32'h0);
    check("arst_pulses", 32'({rx_if.rx_valid, rx_if.rx_sop, rx_if.rx_eop, rx_if.rx_error}), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    push_idle(6);
    play(1'b0);
    snap();
    exp_q.push_back(8'hA5);
    push_idle(2); push_sync(); push_byte(8'hA5); push_eop(); push_idle(4);
    play(1'b0);
    repeat (8) @(negedge clock);
    check_bytes("arst");
    check_counts("arst", 1, 1, 1, 0);

    check("valid_err_overlap", 32'(overlap_cnt), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
